// File: rtl/rf_vote_accumulator.sv
// rtl/rf_vote_accumulator.sv - per-sample random-forest vote histogram and majority reduction
//
// Pops NUM_TREE class votes from the tree-result FIFO, builds a per-class
// histogram, reduces it to the majority class with a one-class-per-cycle
// argmax, and offers the result on a valid/ready port.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_start         begin a new sample (honoured only when idle)
//   i_abort         return to idle from any state, discarding the sample
//   i_vote          FIFO front data (class index)
//   i_vote_vld      i_vote is valid this cycle (pop issued last cycle)
//   i_fifo_empty    FIFO empty flag
//   o_pop           FIFO pop request (combinational)
//   o_busy          high in every state except idle
//   o_result_vld    result valid, held until i_result_rdy
//   i_result_rdy    result accepted when o_result_vld & i_result_rdy
//   o_result_cls    majority class (ties go to lowest index)
//   o_result_cnt    vote count of the majority class
//   o_bad_vote      sticky per sample: a vote >= NUM_CLASS was received

module rf_vote_accumulator #(
  parameter int VOTE_W    = 4,
  parameter int NUM_CLASS = 8,
  parameter int NUM_TREE  = 16,
  parameter int CNT_W     = $clog2(NUM_TREE + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [VOTE_W-1:0] i_vote,
  input  logic              i_vote_vld,
  input  logic              i_fifo_empty,
  output logic              o_pop,
  output logic              o_busy,
  output logic              o_result_vld,
  input  logic              i_result_rdy,
  output logic [VOTE_W-1:0] o_result_cls,
  output logic [CNT_W-1:0]  o_result_cnt,
  output logic              o_bad_vote
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_REDUCE, S_DONE} state_t;

  localparam logic [CNT_W-1:0]  NT       = CNT_W'(NUM_TREE);
  localparam logic [CNT_W-1:0]  NT_M1    = CNT_W'(NUM_TREE - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [VOTE_W-1:0] LAST_IDX = VOTE_W'(NUM_CLASS - 1);
  localparam logic [VOTE_W-1:0] IDX_ONE  = VOTE_W'(1);
  localparam logic [VOTE_W:0]   NC_EXT   = (VOTE_W + 1)'(NUM_CLASS);

  state_t            state;
  logic [CNT_W-1:0]  hist [NUM_CLASS];
  logic [CNT_W-1:0]  pop_cnt;
  logic [CNT_W-1:0]  rcv_cnt;
  logic [VOTE_W-1:0] idx;
  logic [CNT_W-1:0]  cur_cnt;
  logic              vote_ok;

  // Histogram entry under the reduction pointer.
  always_comb begin
    cur_cnt = '0;
    for (int c = 0; c < NUM_CLASS; c++) begin
      if (idx == VOTE_W'(c)) cur_cnt = hist[c];
    end
  end

  assign vote_ok = ({1'b0, i_vote} < NC_EXT);
  assign o_busy  = (state != S_IDLE);
  // Abort suppresses the pop in its own cycle so nothing new enters flight.
  assign o_pop   = (state == S_COLLECT) && !i_abort && !i_fifo_empty && (pop_cnt < NT);

  // o_result_cnt doubles as the running best count during REDUCE; it is
  // cleared on start, so an all-bad sample reduces to cls=0, cnt=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      pop_cnt      <= '0;
      rcv_cnt      <= '0;
      idx          <= '0;
      o_result_vld <= 1'b0;
      o_result_cls <= '0;
      o_result_cnt <= '0;
      o_bad_vote   <= 1'b0;
      for (int c = 0; c < NUM_CLASS; c++) hist[c] <= '0;
    end else if (i_abort) begin
      state        <= S_IDLE;
      o_result_vld <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state        <= S_COLLECT;
            pop_cnt      <= '0;
            rcv_cnt      <= '0;
            idx          <= '0;
            o_result_cls <= '0;
            o_result_cnt <= '0;
            o_bad_vote   <= 1'b0;
            for (int c = 0; c < NUM_CLASS; c++) hist[c] <= '0;
          end
        end
        S_COLLECT: begin
          if (o_pop) pop_cnt <= pop_cnt + CNT_ONE;
          if (i_vote_vld) begin
            rcv_cnt <= rcv_cnt + CNT_ONE;
            if (vote_ok) begin
              for (int c = 0; c < NUM_CLASS; c++) begin
                if (i_vote == VOTE_W'(c)) hist[c] <= hist[c] + CNT_ONE;
              end
            end else begin
              o_bad_vote <= 1'b1;
            end
            if (rcv_cnt == NT_M1) begin
              state <= S_REDUCE;
              idx   <= '0;
            end
          end
        end
        S_REDUCE: begin
          // Strict compare keeps the earliest (lowest) index on ties.
          if (cur_cnt > o_result_cnt) begin
            o_result_cls <= idx;
            o_result_cnt <= cur_cnt;
          end
          if (idx == LAST_IDX) begin
            state        <= S_DONE;
            o_result_vld <= 1'b1;
          end else begin
            idx <= idx + IDX_ONE;
          end
        end
        S_DONE: begin
          if (i_result_rdy) begin
            state        <= S_IDLE;
            o_result_vld <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_vote_accumulator.sv
// tb/tb_rf_vote_accumulator.sv - self-checking bench for rf_vote_accumulator
module tb_rf_vote_accumulator;
  localparam int VOTE_W = 4;
  localparam int CNT_W  = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_start = 1'b0;
  logic i_abort = 1'b0;
  logic i_result_rdy = 1'b1;
  logic [VOTE_W-1:0] i_vote;
  logic i_vote_vld;
  logic i_fifo_empty;
  logic o_pop, o_busy, o_result_vld, o_bad_vote;
  logic [VOTE_W-1:0] o_result_cls;
  logic [CNT_W-1:0] o_result_cnt;

  rf_vote_accumulator dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_vote(i_vote), .i_vote_vld(i_vote_vld), .i_fifo_empty(i_fifo_empty),
    .o_pop(o_pop), .o_busy(o_busy), .o_result_vld(o_result_vld),
    .i_result_rdy(i_result_rdy), .o_result_cls(o_result_cls),
    .o_result_cnt(o_result_cnt), .o_bad_vote(o_bad_vote)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int lat = 0;

  // FIFO model: one-cycle read latency, counts kept per writing process.
  logic [VOTE_W-1:0] fq[$];
  int push_n = 0, pop_n = 0, flush_n = 0;
  logic hold_empty = 1'b0;
  assign i_fifo_empty = hold_empty || ((push_n - pop_n - flush_n) == 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_vote_vld <= 1'b0;
      i_vote     <= '0;
    end else if (o_pop && fq.size() > 0) begin
      i_vote     <= fq.pop_front();
      i_vote_vld <= 1'b1;
      pop_n      <= pop_n + 1;
    end else begin
      i_vote_vld <= 1'b0;
    end
  end

  typedef struct {int cls; int cnt; int bad;} exp_t;
  exp_t sb[$];

  typedef struct {int a_cls; int a_n; int b_cls; int b_n; int e_cls; int e_cnt; int e_bad;} rec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    lat++;
  endtask

  task automatic push_votes(input int cls, input int n);
    for (int i = 0; i < n; i++) begin
      fq.push_back(VOTE_W'(cls));
      push_n++;
    end
  endtask

  task automatic flush_fifo();
    flush_n += fq.size();
    fq.delete();
  endtask

  task automatic start_pulse();
    @(negedge clk);
    i_start = 1'b1;
    lat = 0;
    tick();
    i_start = 1'b0;
    chk("busy_after_start", o_busy, 1);
    chk("bad_clear_on_start", o_bad_vote, 0);
  endtask

  task automatic wait_result(input string name, input int exp_lat);
    exp_t e;
    while (!o_result_vld && lat < 200) tick();
    chk({name, "_latency"}, lat, exp_lat);
    e = sb.pop_front();
    chk({name, "_cls"}, o_result_cls, e.cls);
    chk({name, "_cnt"}, o_result_cnt, e.cnt);
    chk({name, "_bad"}, o_bad_vote, e.bad);
    if (i_result_rdy) begin
      tick();
      chk({name, "_vld_drop"}, o_result_vld, 0);
      chk({name, "_idle"}, o_busy, 0);
    end
  endtask

  rec_t tbl[7];

  initial begin
    int p0;
    exp_t e;
    tbl[0] = '{3, 10, 5, 6, 3, 10, 0};   // clear majority
    tbl[1] = '{6, 8, 2, 8, 2, 8, 0};     // tie -> lowest index
    tbl[2] = '{9, 1, 1, 15, 1, 15, 1};   // one out-of-range vote
    tbl[3] = '{7, 16, 0, 0, 7, 16, 0};   // unanimous, top class; bad clears
    tbl[4] = '{12, 16, 0, 0, 0, 0, 1};   // all bad
    tbl[5] = '{0, 1, 4, 15, 4, 15, 0};
    tbl[6] = '{5, 8, 5, 8, 5, 16, 0};

    repeat (2) @(negedge clk);
    chk("rst_pop", o_pop, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_vld", o_result_vld, 0);
    chk("rst_cls", o_result_cls, 0);
    chk("rst_cnt", o_result_cnt, 0);
    chk("rst_bad", o_bad_vote, 0);
    rst_n = 1'b1;

    for (int k = 0; k < 7; k++) begin
      push_votes(tbl[k].a_cls, tbl[k].a_n);
      push_votes(tbl[k].b_cls, tbl[k].b_n);
      sb.push_back('{tbl[k].e_cls, tbl[k].e_cnt, tbl[k].e_bad});
      p0 = pop_n;
      start_pulse();
      wait_result($sformatf("vec%0d", k), 26);
      chk($sformatf("vec%0d_pops", k), pop_n - p0, 16);
    end

    // Empty FIFO for 5 cycles mid-sample; the 17th vote must stay queued.
    push_votes(2, 11);
    push_votes(4, 6);
    sb.push_back('{2, 11, 0});
    p0 = pop_n;
    start_pulse();
    repeat (3) tick();
    hold_empty = 1'b1;
    #1 chk("stall_pop0", o_pop, 0);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk($sformatf("stall_pop%0d", i), o_pop, 0);
    end
    tick();
    hold_empty = 1'b0;
    wait_result("stall", 31);
    repeat (3) tick();
    chk("stall_pops", pop_n - p0, 16);
    chk("stall_left", fq.size(), 1);
    flush_fifo();

    // Result held while not ready; start ignored during DONE.
    push_votes(2, 9);
    push_votes(7, 7);
    e = '{2, 9, 0};
    sb.push_back(e);
    i_result_rdy = 1'b0;
    p0 = pop_n;
    start_pulse();
    wait_result("hold", 26);
    i_start = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      i_start = 1'b0;
      chk($sformatf("hold_vld%0d", i), o_result_vld, 1);
      chk($sformatf("hold_cls%0d", i), o_result_cls, e.cls);
      chk($sformatf("hold_cnt%0d", i), o_result_cnt, e.cnt);
    end
    i_result_rdy = 1'b1;
    tick();
    chk("hold_vld_drop", o_result_vld, 0);
    chk("hold_idle", o_busy, 0);
    tick();
    chk("hold_start_ignored", o_busy, 0);
    chk("hold_no_pops", pop_n - p0, 16);

    // Abort the cycle after a pop; the in-flight vote must not leak.
    push_votes(4, 16);
    start_pulse();
    repeat (3) tick();
    chk("abort_pre_pop", o_pop, 1);
    tick();
    i_abort = 1'b1;
    #1 chk("abort_pop", o_pop, 0);
    tick();
    i_abort = 1'b0;
    chk("abort_idle", o_busy, 0);
    chk("abort_vld", o_result_vld, 0);
    flush_fifo();
    push_votes(4, 8);
    push_votes(6, 8);
    sb.push_back('{4, 8, 0});
    start_pulse();
    wait_result("post_abort", 26);

    // Async reset mid-COLLECT clears everything at once.
    push_votes(9, 1);
    push_votes(1, 15);
    start_pulse();
    repeat (5) tick();
    chk("pre_rst_bad", o_bad_vote, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pop", o_pop, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_vld", o_result_vld, 0);
    chk("arst_cls", o_result_cls, 0);
    chk("arst_cnt", o_result_cnt, 0);
    chk("arst_bad", o_bad_vote, 0);
    tick();
    flush_fifo();
    rst_n = 1'b1;
    tick();
    chk("arst_stay_idle", o_busy, 0);
    push_votes(7, 16);
    sb.push_back('{7, 16, 0});
    start_pulse();
    wait_result("post_rst", 26);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
